// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate interface between the VGA timing generator (master)
// and the renderers / top level that consume it (slave).
interface vga_sync_gen_if;
    logic       en;
    logic       p_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        input  en,
        output p_tick, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output en,
        input  p_tick, pix_x, pix_y, video_on, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the system clock down to a pixel tick and
// scans pix_x/pix_y over the full line/frame, with registered sync, blanking
// and line/frame pulses aligned to the coordinates currently presented.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    vga_sync_gen_if.master   vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS     = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS     = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       x_nxt, y_nxt;

    logic       p_tick_r, video_on_r, hsync_r, vsync_r, line_start_r, frame_start_r;
    logic [9:0] pix_x_r, pix_y_r;

    function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
        return (x < X_VIS) && (y < Y_VIS);
    endfunction

    function automatic logic hsync_level(input logic [9:0] x);
        return ((x >= HS_FIRST) && (x <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    endfunction

    function automatic logic vsync_level(input logic [9:0] y);
        return ((y >= VS_FIRST) && (y <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    endfunction

    assign tick = (div == DIV_LAST);

    // Coordinates the scan moves to on the next pixel tick
    always_comb begin
        x_nxt = pix_x_r + 10'd1;
        y_nxt = pix_y_r;
        if (pix_x_r == X_LAST) begin
            x_nxt = 10'd0;
            y_nxt = (pix_y_r == Y_LAST) ? 10'd0 : pix_y_r + 10'd1;
        end
    end

    // Divider, scan counters and all aligned outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            div           <= '0;
            p_tick_r      <= 1'b0;
            pix_x_r       <= X_LAST;
            pix_y_r       <= Y_LAST;
            video_on_r    <= 1'b0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (!vga.en) begin
            // Frozen: counters and syncs hold, blanking and pulses drop
            div           <= '0;
            p_tick_r      <= 1'b0;
            video_on_r    <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div      <= tick ? '0 : div + 1'b1;
            p_tick_r <= tick;
            if (tick) begin
                pix_x_r       <= x_nxt;
                pix_y_r       <= y_nxt;
                video_on_r    <= visible(x_nxt, y_nxt);
                hsync_r       <= hsync_level(x_nxt);
                vsync_r       <= vsync_level(y_nxt);
                line_start_r  <= (x_nxt == 10'd0);
                frame_start_r <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
            end else begin
                // Re-evaluated every clock so blanking recovers right after re-enable
                video_on_r    <= visible(pix_x_r, pix_y_r);
                line_start_r  <= 1'b0;
                frame_start_r <= 1'b0;
            end
        end
    end

    assign vga.p_tick      = p_tick_r;
    assign vga.pix_x       = pix_x_r;
    assign vga.pix_y       = pix_y_r;
    assign vga.video_on    = video_on_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-geometry instance (A) that wraps frames
// quickly and a default 640x480 instance (B), both compared every clock
// against a position-index reference model.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if ifa ();
    vga_sync_gen_if ifb ();

    // Small geometry: 24 x 15, hsync at x 18..20, vsync at y 10..11
    vga_sync_gen #(
        .CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
    ) u_a (.clk(clk), .reset(reset), .vga(ifa));

    vga_sync_gen u_b (.clk(clk), .reset(reset), .vga(ifb));

    typedef struct {
        int phase;
        int pos;
        bit vid, pt, ls, fs, hs, vs;
    } model_t;

    model_t ma, mb;

    // Scan position is a single index into the frame; x/y derive from it.
    function automatic model_t step(model_t m, bit r, bit e, int cd,
                                    int hd, int hf, int hsw, int hb,
                                    int vd, int vf, int vsw, int vb, bit pol);
        model_t n = m;
        int ht = hd + hf + hsw + hb;
        int vt = vd + vf + vsw + vb;
        int x, y;
        if (r) begin
            n.phase = 0; n.pos = ht * vt - 1;
            n.vid = 0; n.pt = 0; n.ls = 0; n.fs = 0;
            n.hs = !pol; n.vs = !pol;
        end else if (!e) begin
            n.phase = 0; n.vid = 0; n.pt = 0; n.ls = 0; n.fs = 0;
        end else begin
            n.pt    = (m.phase == cd - 1);
            n.phase = n.pt ? 0 : m.phase + 1;
            if (n.pt) n.pos = (m.pos + 1) % (ht * vt);
            x = n.pos % ht;
            y = n.pos / ht;
            n.vid = (x < hd) && (y < vd);
            n.ls  = n.pt && (x == 0);
            n.fs  = n.pt && (n.pos == 0);
            if (n.pt) begin
                n.hs = (x >= hd + hf && x < hd + hf + hsw) ? pol : !pol;
                n.vs = (y >= vd + vf && y < vd + vf + vsw) ? pol : !pol;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input string t, input model_t m, input int ht,
                           input logic pt, input logic [9:0] px, input logic [9:0] py,
                           input logic vo, input logic hs, input logic vs,
                           input logic ls, input logic fs);
        chk({t, ".p_tick"},      32'(pt), 32'(m.pt));
        chk({t, ".pix_x"},       32'(px), 32'(m.pos % ht));
        chk({t, ".pix_y"},       32'(py), 32'(m.pos / ht));
        chk({t, ".video_on"},    32'(vo), 32'(m.vid));
        chk({t, ".hsync"},       32'(hs), 32'(m.hs));
        chk({t, ".vsync"},       32'(vs), 32'(m.vs));
        chk({t, ".line_start"},  32'(ls), 32'(m.ls));
        chk({t, ".frame_start"}, 32'(fs), 32'(m.fs));
    endtask

    task automatic set_en(input bit v);
        ifa.en = v;
        ifb.en = v;
    endtask

    // One clock: advance the models with the inputs in force, compare off-edge
    task automatic cycle();
        @(posedge clk);
        ma = step(ma, reset, ifa.en, 4, 16, 2, 3, 3, 8, 2, 2, 3, 1'b0);
        mb = step(mb, reset, ifb.en, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        cyc++;
        @(negedge clk);
        chk_all("A", ma, 24, ifa.p_tick, ifa.pix_x, ifa.pix_y, ifa.video_on,
                ifa.hsync, ifa.vsync, ifa.line_start, ifa.frame_start);
        chk_all("B", mb, 800, ifb.p_tick, ifb.pix_x, ifb.pix_y, ifb.video_on,
                ifb.hsync, ifb.vsync, ifb.line_start, ifb.frame_start);
    endtask

    int lsq[$];
    int fsq[$];
    int n;

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        reset = 1'b1;
        set_en(1'b0);

        // Reset for three clocks, then run
        repeat (3) cycle();
        chk("rst.pix_x", 32'(ifb.pix_x), 32'd799);
        chk("rst.pix_y", 32'(ifb.pix_y), 32'd524);
        chk("rst.hsync", 32'(ifb.hsync), 32'd1);
        reset = 1'b0;
        set_en(1'b1);
        repeat (3) cycle();
        chk("start.hold_x", 32'(ifb.pix_x), 32'd799);
        chk("start.hold_vid", 32'(ifb.video_on), 32'd0);
        cycle();
        chk("start.x0", 32'(ifb.pix_x), 32'd0);
        chk("start.y0", 32'(ifb.pix_y), 32'd0);
        chk("start.vid", 32'(ifb.video_on), 32'd1);
        chk("start.fs", 32'(ifb.frame_start), 32'd1);
        chk("start.ls", 32'(ifb.line_start), 32'd1);
        chk("start.A_fs", 32'(ifa.frame_start), 32'd1);
        lsq.push_back(cyc);
        fsq.push_back(cyc);
        cycle();
        chk("start.pulse_len", 32'(ifb.frame_start), 32'd0);

        // Free run until the default instance reaches (300,10)
        n = 0;
        while (!(ifb.pix_x == 10'd300 && ifb.pix_y == 10'd10) && n < 40000) begin
            cycle();
            if (ifb.line_start) lsq.push_back(cyc);
            if (ifa.frame_start) fsq.push_back(cyc);
            n++;
        end
        chk("reach_300_10", 32'(n < 40000), 32'd1);
        chk("line_period0", 32'(lsq[1] - lsq[0]), 32'd3200);
        chk("line_period1", 32'(lsq[2] - lsq[1]), 32'd3200);
        chk("frame_period0", 32'(fsq[1] - fsq[0]), 32'd1440);
        chk("frame_period1", 32'(fsq[2] - fsq[1]), 32'd1440);

        // Freeze for 17 clocks
        set_en(1'b0);
        repeat (17) cycle();
        chk("freeze.x", 32'(ifb.pix_x), 32'd300);
        chk("freeze.y", 32'(ifb.pix_y), 32'd10);
        set_en(1'b1);
        cycle();
        chk("reen.vid", 32'(ifb.video_on), 32'd1);
        repeat (2) cycle();
        chk("reen.x_hold", 32'(ifb.pix_x), 32'd300);
        cycle();
        chk("reen.x_adv", 32'(ifb.pix_x), 32'd301);

        // Mid-frame reset with en high
        repeat (400) cycle();
        reset = 1'b1;
        cycle();
        chk("midrst.x", 32'(ifb.pix_x), 32'd799);
        chk("midrst.y", 32'(ifb.pix_y), 32'd524);
        chk("midrst.vid", 32'(ifb.video_on), 32'd0);
        chk("midrst.vsync", 32'(ifb.vsync), 32'd1);
        chk("midrst.pt", 32'(ifb.p_tick), 32'd0);
        reset = 1'b0;

        // Randomized enable gaps and occasional resets
        for (int i = 0; i < 4000; i++) begin
            set_en($urandom_range(0, 15) != 0);
            reset = ($urandom_range(0, 599) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
